// File: rtl/vram_load_arbiter.sv
// Routes an ioctl download into VRAM through a small write FIFO, sharing the
// single RAM port with video reads; video always wins arbitration.
module vram_load_arbiter #(
  parameter logic [7:0] INDEX = 8'h00,
  parameter int         DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic [7:0]  vid_rdata,
  output logic        vid_rvalid,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        progress,
  output logic        done,
  output logic        overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOADING, DRAINING} state_t;

  logic [23:0]   fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic          done_d;
  logic          wait_q, rd_pend_q, rvalid_q, we_q, done_q, ovf_q;
  logic [7:0]    rdata_q, wdata_q;
  logic [15:0]   addr_q;

  logic        match, accept, full, push, drop, pop;
  logic [23:0] head;

  assign match  = ioctl_download && (ioctl_index == INDEX);
  assign accept = match && ioctl_wr && (ioctl_addr[24:16] == 9'd0);
  assign full   = (count_q == CW'(DEPTH));
  assign push   = accept && !full;
  assign drop   = accept && full;
  assign pop    = !vid_req && (count_q != '0);
  assign head   = fifo_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Drain completes only once the last popped write has actually hit the RAM.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:     if (match) state_d = LOADING;
      LOADING:  if (!ioctl_download) state_d = DRAINING;
      DRAINING: begin
        if (match) state_d = LOADING;
        else if (count_q == '0 && !we_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (push) fifo_q[wr_ptr_q] <= {ioctl_addr[15:0], ioctl_dout};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      done_q    <= 1'b0;
      wait_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      state_q <= state_d;
      done_q  <= done_d;
      wait_q  <= (count_q >= CW'(DEPTH - 1));

      we_q <= pop;
      if (pop) begin
        addr_q  <= head[23:8];
        wdata_q <= head[7:0];
      end else if (vid_req) begin
        addr_q  <= vid_addr;
      end

      rd_pend_q <= vid_req;
      rvalid_q  <= rd_pend_q;
      if (rd_pend_q) rdata_q <= ram_rdata;

      if (state_q == IDLE && match) ovf_q <= 1'b0;
      else if (drop)                ovf_q <= 1'b1;
    end
  end

  assign ioctl_wait = wait_q;
  assign vid_rdata  = rdata_q;
  assign vid_rvalid = rvalid_q;
  assign ram_addr   = addr_q;
  assign ram_we     = we_q;
  assign ram_wdata  = wdata_q;
  assign progress   = (state_q != IDLE);
  assign done       = done_q;
  assign overflow   = ovf_q;
endmodule
